barrel_shifter_16bit: RTL and testbench

- Registered 16-bit barrel shifter: shifts or rotates a 16-bit word by 0-15 positions in a single pass through a log2 mux network.
- Datapath utility for board/score manipulation and bit-mask generation in the game logic.
- Output is registered on the clock; a valid flag tracks each result.

---
 rtl/barrel_shifter_16bit.sv | 125 ++++++++++++
 tb/tb_barrel_shifter_16bit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_16bit.sv
// barrel_shifter_16bit
//   Registered 16-bit shifter/rotator built from four cascaded stages that
//   shift by 1, 2, 4 and 8 positions under control of ctrl[0..3].
//   mode: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
//   Optional build macro BS_PIPE_EN inserts a register after the 2-position
//   stage (latency 2 instead of 1, throughput unchanged).
module barrel_shifter_16bit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   ctrl,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    // One network stage: shift/rotate by sh when en is set, else pass through.
    // Arithmetic right fills from the stage input's MSB; earlier arithmetic
    // stages never alter bit 15, so that always equals the original sign bit.
    function automatic logic [WIDTH-1:0] stage_f(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input logic [4:0]       sh,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        if (!en) begin
            r = d;
        end else begin
            case (m)
                2'b00:   r = d << sh;
                2'b01:   r = d >> sh;
                2'b10:   r = WIDTH'($signed(d) >>> sh);
                2'b11:   r = (d << sh) | (d >> (5'd16 - sh));
                default: r = d;
            endcase
        end
        return r;
    endfunction

    logic [WIDTH-1:0] s0_s;
    logic [WIDTH-1:0] s1_s;
    logic [WIDTH-1:0] s2_s;
    logic [WIDTH-1:0] s3_s;
    logic [WIDTH-1:0] hi_data_s;
    logic [1:0]       hi_ctrl_s;
    logic [1:0]       hi_mode_s;
    logic             hi_valid_s;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;

    // Low half of the network: shifts of 1 and 2 positions.
    always_comb begin
        s0_s = stage_f(in, ctrl[0], 5'd1, mode);
        s1_s = stage_f(s0_s, ctrl[1], 5'd2, mode);
    end

`ifdef BS_PIPE_EN
    logic [WIDTH-1:0] p_data_r;
    logic [1:0]       p_ctrl_r;
    logic [1:0]       p_mode_r;
    logic             p_valid_r;

    // Mid-network pipeline register; payload loads only on valid so that
    // undefined inputs during idle cycles never enter the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data_r  <= 16'h0000;
            p_ctrl_r  <= 2'b00;
            p_mode_r  <= 2'b00;
            p_valid_r <= 1'b0;
        end else begin
            p_valid_r <= in_valid;
            if (in_valid) begin
                p_data_r <= s1_s;
                p_ctrl_r <= ctrl[3:2];
                p_mode_r <= mode;
            end
        end
    end

    // High half is fed from the pipeline register.
    always_comb begin
        hi_data_s  = p_data_r;
        hi_ctrl_s  = p_ctrl_r;
        hi_mode_s  = p_mode_r;
        hi_valid_s = p_valid_r;
    end
`else
    // High half is fed directly from the low half.
    always_comb begin
        hi_data_s  = s1_s;
        hi_ctrl_s  = ctrl[3:2];
        hi_mode_s  = mode;
        hi_valid_s = in_valid;
    end
`endif

    // High half of the network: shifts of 4 and 8 positions.
    always_comb begin
        s2_s = stage_f(hi_data_s, hi_ctrl_s[0], 5'd4, hi_mode_s);
        s3_s = stage_f(s2_s, hi_ctrl_s[1], 5'd8, hi_mode_s);
    end

    // Output register: captures a result on valid, otherwise holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= 16'h0000;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= hi_valid_s;
            if (hi_valid_s) begin
                out_r <= s3_s;
            end
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_barrel_shifter_16bit.sv
// Directed testbench for barrel_shifter_16bit (works with or without BS_PIPE_EN).
module tb_barrel_shifter_16bit;

`ifdef BS_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] in_d;
    logic [3:0]  ctrl_d;
    logic [1:0]  mode_d;
    logic        in_valid;
    logic [15:0] out_d;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    // Expected-result delay line, index 0 = op issued at the latest edge.
    logic [15:0] pv  [0:1];
    logic        pvv [0:1];
    logic [15:0] exp_out;

    barrel_shifter_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_d),
        .ctrl      (ctrl_d),
        .mode      (mode_d),
        .in_valid  (in_valid),
        .out       (out_d),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] ref_model(input logic [15:0] d, input logic [3:0] c,
                                              input logic [1:0] m);
        logic [31:0] t;
        case (m)
            2'b00: t = {16'h0000, d << c};
            2'b01: t = {16'h0000, d >> c};
            2'b10: t = {{16{d[15]}}, d} >> c;
            2'b11: t = {16'h0000, ({d, d} << c) >> 16};
            default: t = 32'h0;
        endcase
        return t[15:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        pv[0] = 16'h0000; pv[1] = 16'h0000;
        pvv[0] = 1'b0;    pvv[1] = 1'b0;
        exp_out = 16'h0000;
    endtask

    // Drive one cycle of stimulus, clock it, then check what should appear now.
    task automatic step(input logic v, input logic [15:0] d, input logic [3:0] c,
                        input logic [1:0] m, input logic [15:0] e, input string tag);
        in_valid = v; in_d = d; ctrl_d = c; mode_d = m;
        @(posedge clk); #1;
        pv[1] = pv[0]; pvv[1] = pvv[0];
        pv[0] = e;     pvv[0] = v;
        if (pvv[LAT-1]) exp_out = pv[LAT-1];
        chk({tag, "_valid"}, {15'h0000, out_valid}, {15'h0000, pvv[LAT-1]});
        chk({tag, "_out"}, out_d, exp_out);
    endtask

    initial begin
        logic [15:0] r;
        clear_model();
        rst_n = 1'b0; in_valid = 1'b1;
        in_d = 16'($urandom); ctrl_d = 4'($urandom); mode_d = 2'($urandom);

        // Reset held with valid, random inputs
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out_d, 16'h0000);
        chk("rst_valid", {15'h0000, out_valid}, 16'h0000);
        in_d = 16'($urandom); ctrl_d = 4'($urandom);
        @(posedge clk); #1;
        chk("rst_out2", out_d, 16'h0000);
        rst_n = 1'b1;
        clear_model();

        step(1'b1, 16'h0000, 4'd0, 2'b00, 16'h0000, "first");

        // Logical left back-to-back
        step(1'b1, 16'd128, 4'd4, 2'b00, 16'd2048,  "ll_128_4");
        step(1'b1, 16'd128, 4'd2, 2'b00, 16'd512,   "ll_128_2");
        step(1'b1, 16'd128, 4'd1, 2'b00, 16'd256,   "ll_128_1");
        step(1'b1, 16'd255, 4'd7, 2'b00, 16'd32640, "ll_255_7");
        step(1'b1, 16'h0003, 4'd15, 2'b00, 16'h8000, "ll_3_15");

        // Right shifts
        step(1'b1, 16'h8000, 4'd15, 2'b01, 16'h0001, "lr_8000_15");
        step(1'b1, 16'h8000, 4'd4,  2'b10, 16'hF800, "ar_8000_4");
        step(1'b1, 16'h7FF0, 4'd4,  2'b10, 16'h07FF, "ar_7ff0_4");
        step(1'b1, 16'h8000, 4'd15, 2'b10, 16'hFFFF, "ar_8000_15");

        // Rotate left
        step(1'b1, 16'h8001, 4'd1, 2'b11, 16'h0003, "rl_8001_1");
        step(1'b1, 16'h1234, 4'd8, 2'b11, 16'h3412, "rl_1234_8");
        step(1'b1, 16'hABCD, 4'd0, 2'b11, 16'hABCD, "rl_abcd_0");

        // Hold with X on inputs while idle
        step(1'b0, 16'hxxxx, 4'bxxxx, 2'bxx, 16'h0000, "hold1");
        step(1'b0, 16'hxxxx, 4'bxxxx, 2'bxx, 16'h0000, "hold2");
        step(1'b0, 16'hxxxx, 4'bxxxx, 2'bxx, 16'h0000, "hold3");

        // Asynchronous reset between edges with a result pending
        in_valid = 1'b1; in_d = 16'h00F0; ctrl_d = 4'd1; mode_d = 2'b00;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", out_d, 16'h0000);
        chk("async_rst_valid", {15'h0000, out_valid}, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        step(1'b0, 16'h0000, 4'd0, 2'b00, 16'h0000, "post_rst1");
        step(1'b0, 16'h0000, 4'd0, 2'b00, 16'h0000, "post_rst2");

        // Sweep of every ctrl and mode on random operands
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 16; c++) begin
                r = 16'($urandom);
                step(1'b1, r, 4'(c), 2'(m), ref_model(r, 4'(c), 2'(m)), "sweep");
            end
        end
        for (int k = 0; k < LAT; k++) begin
            step(1'b0, 16'h0000, 4'd0, 2'b00, 16'h0000, "drain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
